// File: rtl/act_code_pkg.sv
// Shared constants and state type for the activation encoder.
// A 4-bit signed activation maps to a 5-bit macro code. Code 10100 is
// the encoding of zero and doubles as the pad value for unwritten channels.
package act_code_pkg;

    localparam int VAL_W  = 4;
    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_ZERO = 5'b10100;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } act_state_e;

endpackage

// File: rtl/act_code_lut.sv
// Combinational 4-bit signed value to 5-bit macro code mapping.
// The table is the exact inverse of the downstream 5-to-4 decoder.
module act_code_lut
    import act_code_pkg::*;
(
    input  logic [VAL_W-1:0]  val,
    output logic [CODE_W-1:0] code
);

    // Look up the macro code for one signed activation value
    always_comb begin
        code = CODE_ZERO;
        case (val)
            4'b1000: code = 5'b00000;  // -8
            4'b1001: code = 5'b00001;  // -7
            4'b1010: code = 5'b00010;  // -6
            4'b1011: code = 5'b00100;  // -5
            4'b1100: code = 5'b01000;  // -4
            4'b1101: code = 5'b10000;  // -3
            4'b1110: code = 5'b10001;  // -2
            4'b1111: code = 5'b10010;  // -1
            4'b0000: code = 5'b10100;  //  0
            4'b0001: code = 5'b11000;  //  1
            4'b0010: code = 5'b11001;  //  2
            4'b0011: code = 5'b11010;  //  3
            4'b0100: code = 5'b11100;  //  4
            4'b0101: code = 5'b11101;  //  5
            4'b0110: code = 5'b11110;  //  6
            4'b0111: code = 5'b11111;  //  7
            default: code = CODE_ZERO;
        endcase
    end

endmodule

// File: rtl/act_encoder.sv
// Activation frame encoder: collects one word of MACRO_NUM signed values per
// channel, encodes each value to a macro code and presents the whole frame
// once CHANNEL_NUM channels (or an early in_last) have been seen.
// The frame buffer is the output register itself; it is cleared to the pad
// code whenever a frame is handed off or on reset, so short frames read as
// zero in every channel that was not written.
module act_encoder
    import act_code_pkg::*;
#(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [MACRO_NUM-1:0][VAL_W-1:0]               in_data,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][CODE_W-1:0] out_data,
    output logic [$clog2(CHANNEL_NUM+1)-1:0]              out_count,
    output logic                                          out_short
);

    localparam int CNT_W = $clog2(CHANNEL_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNEL_NUM - 1);

    act_state_e                          state_r;
    act_state_e                          state_nx_s;
    logic [CNT_W-1:0]                    ch_cnt_r;
    logic                                accept_s;
    logic                                final_s;
    logic                                handoff_s;
    logic [MACRO_NUM-1:0][CODE_W-1:0]    code_s;

    for (genvar m = 0; m < MACRO_NUM; m++) begin : g_lut
        act_code_lut u_lut (
            .val  (in_data[m]),
            .code (code_s[m])
        );
    end

    // Handshakes depend only on the state register
    assign in_ready  = (state_r == ST_FILL);
    assign out_valid = (state_r == ST_DRAIN);

    // Decode accept/final-word/hand-off conditions and the next state
    always_comb begin
        accept_s   = in_valid && (state_r == ST_FILL);
        final_s    = accept_s && (in_last || (ch_cnt_r == LAST_CH));
        handoff_s  = out_ready && (state_r == ST_DRAIN);
        state_nx_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (final_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame buffer, channel counter and frame summary
    always_ff @(posedge clk) begin
        if (rst || handoff_s) begin
            ch_cnt_r  <= {CNT_W{1'b0}};
            out_data  <= {(CHANNEL_NUM * MACRO_NUM){CODE_ZERO}};
            out_count <= {CNT_W{1'b0}};
            out_short <= 1'b0;
        end else if (accept_s) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                if (ch_cnt_r == CNT_W'(c)) begin
                    out_data[c] <= code_s;
                end
            end
            ch_cnt_r <= ch_cnt_r + CNT_W'(1);
            if (final_s) begin
                out_count <= ch_cnt_r + CNT_W'(1);
                // in_last on the final channel still counts as a full frame
                out_short <= in_last && (ch_cnt_r < LAST_CH);
            end
        end
    end

endmodule

// File: tb/tb_act_encoder.sv
// Directed bench for act_encoder with a frame scoreboard.
module tb_act_encoder;

    localparam int CH = 4;
    localparam int MC = 1;
    localparam logic [4:0] PAD = 5'b10100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [MC-1:0][3:0]      in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH-1:0][MC-1:0][4:0] out_data;
    logic [2:0]              out_count;
    logic                    out_short;

    logic [3:0]              lb_val;
    logic [4:0]              lb_code;

    typedef struct packed {
        logic [CH-1:0][4:0] data;
        logic [2:0]         count;
        logic               short_f;
    } frame_t;

    frame_t exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     first_waits;
    int     w;

    always #5 clk = ~clk;

    act_encoder #(.CHANNEL_NUM(CH), .MACRO_NUM(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_short (out_short)
    );

    act_code_lut u_lb (
        .val  (lb_val),
        .code (lb_code)
    );

    function automatic logic [4:0] enc_model(input logic [3:0] v);
        case (v)
            4'h8: return 5'b00000;
            4'h9: return 5'b00001;
            4'hA: return 5'b00010;
            4'hB: return 5'b00100;
            4'hC: return 5'b01000;
            4'hD: return 5'b10000;
            4'hE: return 5'b10001;
            4'hF: return 5'b10010;
            4'h0: return 5'b10100;
            4'h1: return 5'b11000;
            4'h2: return 5'b11001;
            4'h3: return 5'b11010;
            4'h4: return 5'b11100;
            4'h5: return 5'b11101;
            4'h6: return 5'b11110;
            default: return 5'b11111;
        endcase
    endfunction

    function automatic logic [3:0] dec_model(input logic [4:0] c);
        case (c)
            5'b00000: return 4'h8;
            5'b00001: return 4'h9;
            5'b00010: return 4'hA;
            5'b00100: return 4'hB;
            5'b01000: return 4'hC;
            5'b10000: return 4'hD;
            5'b10001: return 4'hE;
            5'b10010: return 4'hF;
            5'b10100: return 4'h0;
            5'b11000: return 4'h1;
            5'b11001: return 4'h2;
            5'b11010: return 4'h3;
            5'b11100: return 4'h4;
            5'b11101: return 4'h5;
            5'b11110: return 4'h6;
            5'b11111: return 4'h7;
            default:  return 4'hX;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [3:0] v, input logic last, input logic keep,
                              output int waits);
        in_valid   = 1'b1;
        in_data[0] = v;
        in_last    = last;
        waits      = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        if (!keep) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [CH-1:0][3:0] vals, input int n,
                              input logic use_last, input logic keep, output int fw);
        frame_t e;
        int     wt;
        e.data = {CH{PAD}};
        for (int i = 0; i < n; i++) e.data[i] = enc_model(vals[i]);
        e.count   = 3'(n);
        e.short_f = (n < CH);
        exp_q.push_back(e);
        fw = 0;
        for (int i = 0; i < n; i++) begin
            drive_word(vals[i], (i == n - 1) && use_last, (i == n - 1) ? keep : 1'b1, wt);
            if (i == 0) fw = wt;
        end
        check("latency_out_valid", 32'(out_valid), 32'd1);
        check("drain_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic do_drain();
        frame_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_count", 32'(out_count), 32'(e.count));
            check("out_short", 32'(out_short), 32'(e.short_f));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_pad", 32'(out_data), 32'({CH{PAD}}));
        check("post_count", 32'(out_count), 32'd0);
        check("post_short", 32'(out_short), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        lb_val    = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_short", 32'(out_short), 32'd0);
        check("rst_pad", 32'(out_data), 32'({CH{PAD}}));

        // Loopback through the LUT and the decoder model
        for (int i = 0; i < 16; i++) begin
            lb_val = 4'(i);
            #1;
            check("lut_code", 32'(lb_code), 32'(enc_model(lb_val)));
            check("loopback", 32'(dec_model(lb_code)), 32'(lb_val));
        end

        // Full frame 1,-1,7,-8 with in_last on channel 3
        send_frame({4'h8, 4'h7, 4'hF, 4'h1}, 4, 1'b1, 1'b0, w);
        do_drain();

        // Full frame ended by channel count alone
        send_frame({4'h0, 4'hC, 4'h5, 4'h2}, 4, 1'b0, 1'b0, w);
        do_drain();

        // Short frames
        send_frame({4'h0, 4'h0, 4'h0, 4'h3}, 2, 1'b1, 1'b0, w);
        do_drain();
        send_frame({4'h0, 4'h0, 4'h0, 4'hB}, 1, 1'b1, 1'b0, w);
        do_drain();

        // Backpressure with in_valid held high
        send_frame({4'h6, 4'h9, 4'hE, 4'h4}, 4, 1'b1, 1'b0, w);
        in_valid   = 1'b1;
        in_data[0] = 4'h3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(exp_q[0].data));
        end
        in_valid = 1'b0;
        do_drain();

        // Reset mid-frame discards the partial frame
        drive_word(4'h7, 1'b0, 1'b1, w);
        drive_word(4'h6, 1'b0, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_ch_cnt", 32'(dut.ch_cnt_r), 32'd0);
        check("mid_rst_pad", 32'(out_data), 32'({CH{PAD}}));
        send_frame({4'h4, 4'h3, 4'h2, 4'h1}, 4, 1'b1, 1'b0, w);
        do_drain();

        // Back-to-back frames with in_valid held across the hand-off
        send_frame({4'hD, 4'hA, 4'h0, 4'h5}, 4, 1'b1, 1'b1, w);
        in_data[0] = 4'h2;
        in_last    = 1'b0;
        do_drain();
        send_frame({4'h8, 4'h1, 4'hF, 4'h2}, 4, 1'b1, 1'b0, first_waits);
        check("b2b_first_accept", 32'(first_waits), 32'd0);
        do_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/act_encoder.md
ACT_ENCODER -- requirements
Module: act_encoder

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 128, the number of channels per frame.
REQ-002 The block SHALL have parameter MACRO_NUM, default 4, the number of macros per channel.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: the input word is valid.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block can accept an input word.
REQ-007 The block SHALL have the port in_data, input, [3:0] x [MACRO_NUM-1:0]: one signed 4-bit value per macro for the current channel.
REQ-008 The block SHALL have the port in_last, input, 1 bit: the current word is the final channel of the frame.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: the encoded frame is available.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the downstream side accepts the frame.
REQ-011 The block SHALL have the port out_data, output, [4:0] x [CHANNEL_NUM-1:0] x [MACRO_NUM-1:0]: the encoded frame.
REQ-012 The block SHALL have the port out_count, output, $clog2(CHANNEL_NUM+1) bits: the number of channels written in the frame.
REQ-013 The block SHALL have the port out_short, output, 1 bit: the frame was ended by in_last before CHANNEL_NUM channels.

Function
REQ-014 Each 4-bit value SHALL be encoded to a 5-bit macro code as follows:
- -8→00000, -7→00001, -6→00010, -5→00100
- -4→01000, -3→10000, -2→10001, -1→10010
- 0→10100, 1→11000, 2→11001, 3→11010
- 4→11100, 5→11101, 6→11110, 7→11111
REQ-015 The block SHALL have two states:
- FILL: in_ready=1, out_valid=0.
- DRAIN: in_ready=0, out_valid=1.
REQ-016 An input word SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 On acceptance, all MACRO_NUM values SHALL be encoded and written to buffer entry ch_cnt, and ch_cnt SHALL increment.
REQ-018 If the accepted word has ch_cnt==CHANNEL_NUM-1 or in_last=1, then on the same edge:
- the state SHALL go to DRAIN;
- out_count SHALL be set to the channels written, including this one;
- out_short SHALL be set to (in_last && ch_cnt<CHANNEL_NUM-1).
REQ-019 Latency: out_valid SHALL be 1 on the cycle after the final accepted word.
REQ-020 In DRAIN, out_data, out_count and out_short SHALL hold stable until out_ready=1.
REQ-021 A DRAIN-to-FILL transition on out_ready=1 SHALL, on that edge:
- set ch_cnt to 0;
- set every buffer entry to the pad code 10100 (zero);
- clear out_count and out_short.
REQ-022 Channels not written in a short frame SHALL read as pad code 10100.
REQ-023 in_last at ch_cnt==CHANNEL_NUM-1 SHALL be treated as a full frame (out_short=0).
REQ-024 No input word SHALL be accepted in DRAIN. The cycle of the out_ready handshake SHALL NOT accept input, so the earliest next accept is the following cycle.
REQ-025 in_valid, in_data and in_last SHALL be ignored whenever in_ready=0.
REQ-026 in_ready and out_valid SHALL be driven from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 rst=1 SHALL force, on the next edge, regardless of state and including mid-frame or mid-drain:
- state FILL, ch_cnt=0;
- every buffer entry 10100;
- out_valid=0, in_ready=1;
- out_count=0, out_short=0.
REQ-028 A partial frame in progress at reset SHALL be discarded and never presented.

Structure
REQ-029 The code constants (CODE_ZERO=5'b10100, code width 5, value width 4) and the state enum SHALL live in the shared package act_code_pkg.
REQ-030 The 4-to-5 mapping SHALL be one combinational sub-module, act_code_lut, instantiated MACRO_NUM times.
REQ-031 act_code_lut SHALL be the exact inverse of the existing 5-to-4 decoder for all 16 values.

Verification
REQ-032 Loopback test: drive values -8..7 through act_code_lut and then the existing decoder -> the output equals the input for all 16 values.
REQ-033 Full frame test (CHANNEL_NUM=4, MACRO_NUM=1, values 1,-1,7,-8, in_last at channel 3) -> out_data = {11000,10010,11111,00000}, out_count=4, out_short=0, out_valid on the cycle after the 4th accept.
REQ-034 Short frame test: 2 words (3, 0), in_last on the 2nd -> channels 2..3 = 10100, out_count=2, out_short=1.
REQ-035 Backpressure test: hold out_ready=0 for 10 cycles in DRAIN while in_valid=1 -> in_ready stays 0, out_data stays stable, no accept; out_ready=1 -> FILL on the next cycle.
REQ-036 Reset test: rst after 2 of 4 words -> out_valid=0, ch_cnt=0; a following full frame outputs only new data with no stale entries.
REQ-037 Back-to-back test: two frames with in_valid held at 1 -> exactly one idle accept cycle between the out_ready handshake and the first word of frame 2.
